dma_scheduler: RTL
==================

Name: dma_scheduler

Overview:
- Shares the single dma engine (ROM→RAM copier) among NUM_REQ requesters.
- Each requester presents a transfer descriptor: amount, ROM start, RAM start.
- The scheduler arbitrates round-robin, latches the winner's descriptor onto the dma configuration inputs, holds start_dma until the engine reports done, then acknowledges the requester.
- Sits between client blocks and the dma instance; it is the only driver of the dma's start_dma, data_amt, starting_rom and starting_ram.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 4: width of amount and address fields; matches dma ADDR_WIDTH.
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT (used only with DMA_SCHED_TIMEOUT_EN).

Ports:
- clk in 1: clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- req in NUM_REQ: per-requester request level; held until matching ack.
- req_amt in NUM_REQ*ADDR_WIDTH: flattened amounts; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_rom in NUM_REQ*ADDR_WIDTH: flattened ROM start addresses.
- req_ram in NUM_REQ*ADDR_WIDTH: flattened RAM start addresses.
- ack out NUM_REQ: one-cycle completion pulse, one-hot.
- busy out 1: high in any state other than IDLE.
- grant_id out $clog2(NUM_REQ): index of current or last granted requester.
- start_dma out 1: to dma.
- data_amt out ADDR_WIDTH: to dma.
- starting_rom out ADDR_WIDTH: to dma.
- starting_ram out ADDR_WIDTH: to dma.
- dma_done in 1: dma done.
- timeout_err out 1: one-cycle pulse concurrent with ack on watchdog expiry; constant 0 without the macro.

Behaviour:
- Reset (reset=0, async): state=IDLE. ack, busy, start_dma, data_amt, starting_rom, starting_ram, timeout_err all 0. grant_id=0. Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE → START: when |req and dma_done==0.
    - Winner is the first set req scanning from last+1 upward, wrapping.
    - Latch winner's descriptor into the output registers; grant_id=winner.
  - IDLE holds while dma_done==1, guarding against a stale done from the previous transfer.
  - START: start_dma=1.
    - Latched data_amt==0: skip the engine, go to ACK, start_dma stays 0.
    - Otherwise go to WAIT.
  - WAIT: start_dma held 1 until dma_done==1 is sampled, then → ACK.
    - dma_done is sampled only in WAIT.
  - ACK: start_dma=0, ack[grant_id]=1 for exactly this cycle, last=grant_id, → IDLE.
- Latency: req rising in cycle N gives start_dma=1 in cycle N+2 (registered). ack follows one cycle after dma_done is sampled.
- Descriptor outputs are stable from START through ACK. Changes on req_* inputs during a transfer are ignored.
- req deasserted mid-transfer: no abort; the transfer completes and ack still pulses.
- Requester re-requesting in the ACK cycle: eligible in IDLE, but loses to any other pending requester due to rotation.
- Reset mid-transfer: immediate return to IDLE, start_dma drops, no ack.

Optional Feature:
- Macro DMA_SCHED_TIMEOUT_EN.
- Defined:
  - Counter cleared on entering WAIT, increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without dma_done → ACK with timeout_err=1 alongside ack.
- Undefined:
  - No counter; WAIT lasts indefinitely; timeout_err tied 0.

Decomposition:
- Package dma_sched_pkg:
  - state enum (IDLE, START, WAIT, ACK).
  - Packed struct dma_desc_t {amt, rom, ram}, parameterised via ADDR_WIDTH localparam.
  - Helper function for index width.
- Sub-module rr_arbiter:
  - Combinational grant from req and last pointer, one-hot plus index.
  - Reusable by other shared-resource blocks.

Test Plan:
- Single request: req[0]=1, amt=10, rom=1, ram=5. → start_dma=1 two cycles later, data_amt=10/starting_rom=1/starting_ram=5. dma_done after 10 cycles → ack[0] pulse, busy falls.
- Round-robin: req=4'b1111 held, each amt=3. → grant order 0,1,2,3,0; exactly one ack per transfer.
- Zero length: req[2]=1, amt=0. → start_dma never asserts, ack[2] pulses 2 cycles after grant.
- Stale done: dma_done held 1 for 3 cycles after ack while req[1]=1. → no grant until dma_done=0.
- Reset mid-WAIT: reset=0 during transfer. → start_dma=0, busy=0, grant_id=0 immediately; no ack.
- Timeout (macro on, TIMEOUT_CYCLES=64): dma_done never asserted. → ack and timeout_err pulse 64 cycles after WAIT entry. Macro off: busy stays 1.

Source files
------------

// File: rtl/dma_sched_pkg.sv
// Shared types and helpers for the DMA scheduler and its round-robin arbiter.
package dma_sched_pkg;

    localparam int DESC_WIDTH = 4;

    // FSM state encoding; kept as plain constants for legacy tool flows.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_ACK   = 2'd3;

    typedef struct packed {
        logic [DESC_WIDTH-1:0] amt;
        logic [DESC_WIDTH-1:0] rom;
        logic [DESC_WIDTH-1:0] ram;
    } dma_desc_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request after the last
// granted index wins, wrapping around. Produces a one-hot grant plus its index.
module rr_arbiter
    import dma_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    int cand;

    // NOTE: every output gets a default first so no path through the loop infers a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/dma_scheduler.sv
// Round-robin scheduler sharing one ROM->RAM DMA engine among NUM_REQ requesters.
// Optional watchdog in WAIT is enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_scheduler
    import dma_sched_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int ADDR_WIDTH     = DESC_WIDTH,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int IW             = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_amt,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rom,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_ram,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          busy,
    output logic [IW-1:0]                 grant_id,
    output logic                          start_dma,
    output logic [ADDR_WIDTH-1:0]         data_amt,
    output logic [ADDR_WIDTH-1:0]         starting_rom,
    output logic [ADDR_WIDTH-1:0]         starting_ram,
    input  logic                          dma_done,
    output logic                          timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("dma_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_t              state;
    logic [IW-1:0]       last;
    logic [NUM_REQ-1:0]  win_oh;
    logic [IW-1:0]       win_idx;
    logic                win_valid;
    logic [ADDR_WIDTH-1:0] win_amt, win_rom, win_ram;
    logic                timeout_hit;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req),
        .last      (last),
        .grant     (win_oh),
        .grant_idx (win_idx),
        .valid     (win_valid)
    );

    always_comb begin
        win_amt = '0;
        win_rom = '0;
        win_ram = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_amt |= req_amt[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_rom |= req_rom[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_ram |= req_ram[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef DMA_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_START)
                wait_cnt <= '0;
            else if (state == ST_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            // A real done in the expiry cycle wins over the watchdog.
            timeout_err <= timeout_hit && !dma_done;
        end
    end

    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // NOTE: all state and output registers use non-blocking assignment so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            last         <= IW'(NUM_REQ - 1);
            grant_id     <= '0;
            ack          <= '0;
            start_dma    <= 1'b0;
            data_amt     <= '0;
            starting_rom <= '0;
            starting_ram <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A done still high from the previous transfer must not start a new one.
                    if (win_valid && !dma_done) begin
                        data_amt     <= win_amt;
                        starting_rom <= win_rom;
                        starting_ram <= win_ram;
                        grant_id     <= win_idx;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    if (data_amt == '0) begin
                        ack[grant_id] <= 1'b1;
                        state         <= ST_ACK;
                    end else begin
                        start_dma <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dma_done || timeout_hit) begin
                        start_dma     <= 1'b0;
                        ack[grant_id] <= 1'b1;
                        state         <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack   <= '0;
                    last  <= grant_id;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
